// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_arbiter
// Purpose  : Shares one asynchronous ROM between an instruction-fetch port and
//            a data-table port. One transfer in flight; each transfer is
//            IDLE (sample) -> ACCESS (ROM_WAIT+1 cycles) -> RESP (ack pulse).
// Revision : 1.0 - initial release
//
// Parameters
//   ROM_WAIT  ROM wait states per access, 0..7 (3-bit counter)
//
// Build option
//   ROM_ARB_RR_EN  defined   : round-robin on simultaneous requests
//                  undefined : fixed priority, instruction fetch wins
//
// Ports
//   clk       in   1   rising-edge clock
//   rst_n     in   1   synchronous active-low reset
//   if_req    in   1   instruction-fetch request (level, held until ack)
//   if_addr   in  16   instruction-fetch byte address
//   if_ack    out  1   one-cycle pulse, if_data valid
//   if_data   out  8   registered fetch data
//   dt_req    in   1   data-table request (level, held until ack)
//   dt_addr   in  16   data-table byte address
//   dt_ack    out  1   one-cycle pulse, dt_data valid
//   dt_data   out  8   registered data-table data
//   rom_addr  out 16   registered ROM address (held while idle)
//   rom_data  in   8   ROM read data, combinational from rom_addr
//   busy      out  1   high whenever a transfer is in flight
// ============================================================================
module rom_arbiter #(
  parameter int unsigned ROM_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_ack,
  output logic [7:0]  if_data,
  input  logic        dt_req,
  input  logic [15:0] dt_addr,
  output logic        dt_ack,
  output logic [7:0]  dt_data,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        busy
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_ACCESS = 2'd1;
  localparam logic [1:0] c_RESP   = 2'd2;

  localparam logic [2:0] c_WAIT = 3'(ROM_WAIT);

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_rom_addr;
  logic [7:0]  r_if_data;
  logic [7:0]  r_dt_data;
  logic        r_if_ack;
  logic        r_dt_ack;
  logic        r_sel_dt;   // winner of the transfer in flight: 1 = data table

  logic        w_any_req;
  logic        w_gnt_dt;

  assign w_any_req = if_req | dt_req;

`ifdef ROM_ARB_RR_EN
  // Last granted requester; resets to data-table so the first contested
  // grant after reset goes to instruction fetch.
  logic r_last_dt;

  assign w_gnt_dt = dt_req & (~if_req | ~r_last_dt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last_dt <= 1'b1;
    end else if ((r_state == c_IDLE) && w_any_req) begin
      r_last_dt <= w_gnt_dt;
    end
  end
`else
  // Fixed priority: data table only wins when instruction fetch is silent.
  assign w_gnt_dt = dt_req & ~if_req;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= 3'd0;
      r_rom_addr <= 16'h0000;
      r_if_data  <= 8'h00;
      r_dt_data  <= 8'h00;
      r_if_ack   <= 1'b0;
      r_dt_ack   <= 1'b0;
      r_sel_dt   <= 1'b0;
    end else begin
      // Acks are single-cycle pulses raised only on the ACCESS->RESP edge.
      r_if_ack <= 1'b0;
      r_dt_ack <= 1'b0;
      case (r_state)
        c_IDLE: begin
          // rom_addr is only loaded on a grant, so it stays stable while idle.
          if (w_any_req) begin
            r_state    <= c_ACCESS;
            r_cnt      <= c_WAIT;
            r_sel_dt   <= w_gnt_dt;
            r_rom_addr <= w_gnt_dt ? dt_addr : if_addr;
          end
        end
        c_ACCESS: begin
          if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
          end else begin
            r_state <= c_RESP;
            if (r_sel_dt) begin
              r_dt_data <= rom_data;
              r_dt_ack  <= 1'b1;
            end else begin
              r_if_data <= rom_data;
              r_if_ack  <= 1'b1;
            end
          end
        end
        c_RESP: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign if_ack   = r_if_ack;
  assign if_data  = r_if_data;
  assign dt_ack   = r_dt_ack;
  assign dt_data  = r_dt_data;
  assign rom_addr = r_rom_addr;
  assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire
